// File: rtl/alu_op_sequencer_if.sv
// Operand/result bus between alu_op_sequencer and its environment.
// Carries the request channel, AluGate operand/result wires, the response
// channel, the register preload port and the completed-op counter.
// The master modport is the sequencer; slave is the driving environment.
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int FUNC_WIDTH = 3
);
    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [FUNC_WIDTH-1:0] req_func_i;
    logic [ADDR_W-1:0]     req_rs1_i;
    logic [ADDR_W-1:0]     req_rs2_i;
    logic [ADDR_W-1:0]     req_rd_i;

    logic [DATA_WIDTH-1:0] alu_rs1_o;
    logic [DATA_WIDTH-1:0] alu_rs2_o;
    logic [FUNC_WIDTH-1:0] alu_func_o;
    logic [DATA_WIDTH-1:0] alu_rd_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  rsp_err_o;

    logic                  pl_en_i;
    logic [ADDR_W-1:0]     pl_addr_i;
    logic [DATA_WIDTH-1:0] pl_data_i;

    logic [31:0]           op_count_o;

    modport master (
        input  req_valid_i, req_func_i, req_rs1_i, req_rs2_i, req_rd_i,
        output req_ready_o,
        output alu_rs1_o, alu_rs2_o, alu_func_o,
        input  alu_rd_i,
        output rsp_valid_o, rsp_data_o, rsp_err_o,
        input  rsp_ready_i,
        input  pl_en_i, pl_addr_i, pl_data_i,
        output op_count_o
    );

    modport slave (
        output req_valid_i, req_func_i, req_rs1_i, req_rs2_i, req_rd_i,
        input  req_ready_o,
        input  alu_rs1_o, alu_rs2_o, alu_func_o,
        output alu_rd_i,
        input  rsp_valid_o, rsp_data_o, rsp_err_o,
        output rsp_ready_i,
        output pl_en_i, pl_addr_i, pl_data_i,
        input  op_count_o
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the AluGate operand/result interface.
// Owns a NUM_REGS x DATA_WIDTH register file (r0 reads as zero), accepts one
// instruction at a time, drives operands to AluGate, writes the result back
// and returns it on a valid/ready response channel.
// Optional build macro: SP_ALU_SEQ_RAW_CHECK_EN adds the raw_hit_o diagnostic.
// Func codes mirror simple_processor_pkg: AND=0, OR=1, XOR=2, NOT=3, INVALID=7;
// every other code is treated as INVALID.
module alu_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int FUNC_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    alu_op_sequencer_if.master   bus
`ifdef SP_ALU_SEQ_RAW_CHECK_EN
    ,
    output logic                 raw_hit_o
`endif
);
    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    typedef enum logic [FUNC_WIDTH-1:0] {
        FN_AND     = 'd0,
        FN_OR      = 'd1,
        FN_XOR     = 'd2,
        FN_NOT     = 'd3,
        FN_INVALID = 'd7
    } func_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [FUNC_WIDTH-1:0] r_func;
    logic                  r_func_ok;
    logic [ADDR_W-1:0]     r_rd;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_err;
    logic [31:0]           r_op_count;

    logic                  w_accept;
    logic                  w_rsp_fire;
    logic                  w_func_ok;
    logic [DATA_WIDTH-1:0] w_rs1_val;
    logic [DATA_WIDTH-1:0] w_rs2_val;
    logic                  w_wr_en;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Register-file read ports: r0 and out-of-range addresses read as zero
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (bus.req_rs1_i != '0 && 32'(bus.req_rs1_i) < NUM_REGS)
            w_rs1_val = r_regs[bus.req_rs1_i];
        if (bus.req_rs2_i != '0 && 32'(bus.req_rs2_i) < NUM_REGS)
            w_rs2_val = r_regs[bus.req_rs2_i];
    end

    // Classify the incoming func code; anything unmapped behaves as INVALID
    always_comb begin
        w_func_ok = 1'b0;
        case (bus.req_func_i)
            FN_AND, FN_OR, FN_XOR, FN_NOT: w_func_ok = 1'b1;
            default:                       w_func_ok = 1'b0;
        endcase
    end

    // Single write port: write-back owns it in EXEC, preload elsewhere
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (r_state == S_EXEC) begin
            w_wr_en   = r_func_ok && (r_rd != '0) && (32'(r_rd) < NUM_REGS);
            w_wr_addr = r_rd;
            w_wr_data = bus.alu_rd_i;
        end else begin
            w_wr_en   = bus.pl_en_i && (bus.pl_addr_i != '0) && (32'(bus.pl_addr_i) < NUM_REGS);
            w_wr_addr = bus.pl_addr_i;
            w_wr_data = bus.pl_data_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake/response outputs
    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_rsp_fire      = 1'b0;
        bus.req_ready_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_data_o  = '0;
        bus.rsp_err_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_data_o  = r_result;
                bus.rsp_err_o   = r_err;
                if (bus.rsp_ready_i) begin
                    w_rsp_fire   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: register file, operand/instruction capture, result, counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_regs     <= '{default: '0};
            r_op1      <= '0;
            r_op2      <= '0;
            r_func     <= '0;
            r_func_ok  <= 1'b0;
            r_rd       <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_wr_en)
                r_regs[w_wr_addr] <= w_wr_data;
            if (w_accept) begin
                r_op1     <= w_rs1_val;
                r_op2     <= w_rs2_val;
                r_func    <= bus.req_func_i;
                r_func_ok <= w_func_ok;
                r_rd      <= bus.req_rd_i;
            end
            if (r_state == S_EXEC) begin
                r_result <= r_func_ok ? bus.alu_rd_i : '0;
                r_err    <= !r_func_ok;
            end
            if (w_rsp_fire)
                r_op_count <= r_op_count + 32'd1;
        end
    end

    // Operand and counter outputs come straight from their registers
    always_comb begin
        bus.alu_rs1_o  = r_op1;
        bus.alu_rs2_o  = r_op2;
        bus.alu_func_o = r_func;
        bus.op_count_o = r_op_count;
    end

`ifdef SP_ALU_SEQ_RAW_CHECK_EN
    // Flag a pending request that reads the register just written back
    always_comb begin
        raw_hit_o = (r_state == S_RESP) && bus.req_valid_i && !r_err && (r_rd != '0) &&
                    ((bus.req_rs1_i == r_rd) || (bus.req_rs2_i == r_rd));
    end
`endif

endmodule
